alu_wide_op_sequencer: RTL and testbench

- Runs 128-bit ALU operations by sequencing the 32-bit ALU one word at a time, least-significant word first.
- Arithmetic operations chain the carry between words; zero, sign, carry and overflow are accumulated into full-width flags.
- Sits between the instruction/issue logic (request side) and the combinational 32-bit ALU (datapath side).
- Returns one 128-bit result plus c/z/s/o flags per request over a valid/ready handshake.

---
 rtl/alu_wide_op_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_wide_op_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_op_sequencer.sv
// rtl/alu_wide_op_sequencer.sv - sequences a narrow combinational ALU across a wide operand
//
// Runs one WORD_W*NUM_WORDS-bit operation by feeding the external WORD_W-bit
// ALU one word per cycle, least-significant word first. Arithmetic mode chains
// the carry between words. Zero/sign/carry/overflow are reported for the full
// width.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_opsel, req_mode, req_cin    opcode, 1=arithmetic/0=logic, carry into word 0
//   req_a, req_b                    wide operands
//   alu_a, alu_b, alu_opsel,
//   alu_mode, alu_cin               current word slice and controls to the ALU
//   alu_result, alu_c_flag,
//   alu_o_flag                      combinational ALU response for that slice
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_c/z/s/o         wide result and full-width flags
//   busy                            high while an operation is in flight
module alu_wide_op_sequencer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  req_opsel,
  input  logic                        req_mode,
  input  logic                        req_cin,
  input  logic [WORD_W*NUM_WORDS-1:0] req_a,
  input  logic [WORD_W*NUM_WORDS-1:0] req_b,
  output logic [WORD_W-1:0]           alu_a,
  output logic [WORD_W-1:0]           alu_b,
  output logic [2:0]                  alu_opsel,
  output logic                        alu_mode,
  output logic                        alu_cin,
  input  logic [WORD_W-1:0]           alu_result,
  input  logic                        alu_c_flag,
  input  logic                        alu_o_flag,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WORD_W*NUM_WORDS-1:0] rsp_result,
  output logic                        rsp_c,
  output logic                        rsp_z,
  output logic                        rsp_s,
  output logic                        rsp_o,
  output logic                        busy
);

  localparam int DATA_W = WORD_W * NUM_WORDS;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          opsel_q, opsel_d;
  logic                mode_q, mode_d;
  logic                cin_q, cin_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [IDX_W-1:0]    word_idx_q, word_idx_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                carry_q, carry_d;
  logic                zero_acc_q, zero_acc_d;
  logic                c_flag_q, c_flag_d;
  logic                o_flag_q, o_flag_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      opsel_q    <= '0;
      mode_q     <= 1'b0;
      cin_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      word_idx_q <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      c_flag_q   <= 1'b0;
      o_flag_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      opsel_q    <= opsel_d;
      mode_q     <= mode_d;
      cin_q      <= cin_d;
      a_q        <= a_d;
      b_q        <= b_d;
      word_idx_q <= word_idx_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_acc_q <= zero_acc_d;
      c_flag_q   <= c_flag_d;
      o_flag_q   <= o_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opsel_d    = opsel_q;
    mode_d     = mode_q;
    cin_d      = cin_q;
    a_d        = a_q;
    b_d        = b_q;
    word_idx_d = word_idx_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_acc_d = zero_acc_q;
    c_flag_d   = c_flag_q;
    o_flag_d   = o_flag_q;

    req_ready  = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_opsel  = '0;
    alu_mode   = 1'b0;
    alu_cin    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_result = '0;
    rsp_c      = 1'b0;
    rsp_z      = 1'b0;
    rsp_s      = 1'b0;
    rsp_o      = 1'b0;
    busy       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          opsel_d    = req_opsel;
          mode_d     = req_mode;
          cin_d      = req_cin;
          a_d        = req_a;
          b_d        = req_b;
          word_idx_d = '0;
          result_d   = '0;
          carry_d    = 1'b0;
          zero_acc_d = 1'b1;
          c_flag_d   = 1'b0;
          o_flag_d   = 1'b0;
          state_d    = ST_EXEC;
        end
      end

      ST_EXEC: begin
        busy      = 1'b1;
        alu_a     = a_q[word_idx_q*WORD_W +: WORD_W];
        alu_b     = b_q[word_idx_q*WORD_W +: WORD_W];
        alu_opsel = opsel_q;
        alu_mode  = mode_q;
        // Word 0 takes the request carry; later words take the previous
        // word's carry-out. Logic ops never see a carry.
        alu_cin   = mode_q & ((word_idx_q == '0) ? cin_q : carry_q);

        result_d[word_idx_q*WORD_W +: WORD_W] = alu_result;
        carry_d    = alu_c_flag;
        zero_acc_d = zero_acc_q & (alu_result == '0);

        if (word_idx_q == LAST_IDX) begin
          // Top-word carry is reported only; it is never wrapped to word 0.
          c_flag_d = alu_c_flag;
          o_flag_d = alu_o_flag;
          state_d  = ST_DONE;
        end else begin
          word_idx_d = word_idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        busy       = 1'b1;
        rsp_valid  = 1'b1;
        rsp_result = result_q;
        rsp_c      = mode_q & c_flag_q;
        rsp_z      = zero_acc_q;
        rsp_s      = result_q[DATA_W-1];
        rsp_o      = mode_q & o_flag_q;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_wide_op_sequencer.sv
// tb/tb_alu_wide_op_sequencer.sv - self-checking bench for alu_wide_op_sequencer
module tb_alu_wide_op_sequencer;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_opsel;
  logic         req_mode;
  logic         req_cin;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [2:0]   alu_opsel;
  logic         alu_mode;
  logic         alu_cin;
  logic [31:0]  alu_result;
  logic         alu_c_flag;
  logic         alu_o_flag;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_result;
  logic         rsp_c;
  logic         rsp_z;
  logic         rsp_s;
  logic         rsp_o;
  logic         busy;

  always #5 clk = ~clk;

  alu_wide_op_sequencer #(.WORD_W(32), .NUM_WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opsel  (req_opsel),
    .req_mode   (req_mode),
    .req_cin    (req_cin),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opsel  (alu_opsel),
    .alu_mode   (alu_mode),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_c_flag (alu_c_flag),
    .alu_o_flag (alu_o_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_c      (rsp_c),
    .rsp_z      (rsp_z),
    .rsp_s      (rsp_s),
    .rsp_o      (rsp_o),
    .busy       (busy)
  );

  // Combinational 32-bit ALU on the datapath side.
  logic [31:0] alu_bv;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bv     = (alu_opsel == OP_SUB) ? ~alu_b : alu_b;
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_bv} + {32'd0, alu_cin};
    alu_result = '0;
    alu_c_flag = 1'b0;
    alu_o_flag = 1'b0;
    if (alu_mode) begin
      alu_result = alu_sum[31:0];
      alu_c_flag = alu_sum[32];
      alu_o_flag = (alu_a[31] == alu_bv[31]) && (alu_sum[31] != alu_a[31]);
    end else begin
      case (alu_opsel)
        OP_OR:   alu_result = alu_a | alu_b;
        OP_XOR:  alu_result = alu_a ^ alu_b;
        default: alu_result = alu_a & alu_b;
      endcase
    end
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string nm, input logic [131:0] got, input logic [131:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Whole-width reference: returns {c, z, s, o, result}.
  function automatic logic [131:0] ref_op(input logic mode, input logic [2:0] op,
                                          input logic cin, input logic [127:0] a,
                                          input logic [127:0] b);
    logic [128:0] sum;
    logic [127:0] bb, r;
    logic         c, o;
    c = 1'b0;
    o = 1'b0;
    if (mode) begin
      bb  = (op == OP_SUB) ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {128'd0, cin};
      r   = sum[127:0];
      c   = sum[128];
      o   = (a[127] == bb[127]) && (r[127] != a[127]);
    end else begin
      case (op)
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        default: r = a & b;
      endcase
    end
    return {c, (r == 128'd0), r[127], o, r};
  endfunction

  // Entered #1 after the accepting edge; waits for rsp_valid and checks it.
  task automatic wait_and_check(input string tag, input logic [131:0] exp,
                                input logic mode, input bit scramble);
    int lat;
    bit cin_bad;
    lat     = 0;
    cin_bad = 0;
    while (!rsp_valid && lat < 20) begin
      if (!mode && busy && alu_cin !== 1'b0) cin_bad = 1;
      if (scramble) begin
        req_a = rand128();
        req_b = rand128();
      end
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s latency", tag), 132'(lat), 132'd4);
    check($sformatf("%s result", tag), {4'd0, rsp_result}, {4'd0, exp[127:0]});
    check($sformatf("%s flags czso", tag), 132'({rsp_c, rsp_z, rsp_s, rsp_o}),
          132'(exp[131:128]));
    if (!mode) check($sformatf("%s alu_cin zero", tag), 132'(cin_bad), 132'd0);
  endtask

  task automatic do_op(input string tag, input logic mode, input logic [2:0] op,
                       input logic cin, input logic [127:0] a, input logic [127:0] b,
                       input logic [131:0] exp, input bit scramble);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_mode  = mode;
    req_opsel = op;
    req_cin   = cin;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_and_check(tag, exp, mode, scramble);
    @(posedge clk); #1;
    check($sformatf("%s retire ready/valid", tag), 132'({req_ready, rsp_valid}), 132'(2'b10));
  endtask

  typedef struct {
    logic         mode;
    logic [2:0]   op;
    logic         cin;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] res;
    logic         c, z, s, o;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [131:0] exp;
    logic [131:0] snap;
    logic [127:0] a, b;
    logic         mode, cin;
    logic [2:0]   op;
    bit           ok, saw;

    tbl[0] = '{1'b1, OP_ADD, 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
               128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, OP_ADD, 1'b0, {128{1'b1}}, 128'd1, 128'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, OP_ADD, 1'b0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, OP_AND, 1'b1, {16{8'hF0}}, {16{8'h0F}}, 128'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, OP_ADD, 1'b0, 128'd5, 128'd7, 128'd12, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, OP_SUB, 1'b1, 128'd0, 128'd1, {128{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_opsel = '0;
    req_mode  = 1'b0;
    req_cin   = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2;
    check("reset ready/valid/busy", 132'({req_ready, rsp_valid, busy}), 132'(3'b100));
    check("reset alu outputs", 132'({alu_a, alu_b, alu_opsel, alu_mode, alu_cin}), 132'd0);
    check("reset rsp outputs", {rsp_c, rsp_z, rsp_s, rsp_o, rsp_result}, 132'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].mode, tbl[i].op, tbl[i].cin, tbl[i].a, tbl[i].b,
            {tbl[i].c, tbl[i].z, tbl[i].s, tbl[i].o, tbl[i].res}, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      mode = 1'($urandom_range(0, 1));
      op   = mode ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 4));
      cin  = 1'($urandom_range(0, 1));
      a    = rand128();
      b    = rand128();
      if (i % 8 == 0) a = {128{1'b1}};
      do_op($sformatf("rnd%0d", i), mode, op, cin, a, b, ref_op(mode, op, cin, a, b),
            (i % 3 == 0));
    end

    // Operands altered every cycle after the accept.
    a = rand128();
    b = rand128();
    do_op("scramble", 1'b1, OP_ADD, 1'b1, a, b, ref_op(1'b1, OP_ADD, 1'b1, a, b), 1'b1);

    // Backpressure with a competing request held valid.
    rsp_ready = 1'b0;
    a = rand128();
    b = rand128();
    req_mode  = 1'b1;
    req_opsel = OP_ADD;
    req_cin   = 1'b0;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    wait_and_check("bp first", ref_op(1'b1, OP_ADD, 1'b0, a, b), 1'b1, 1'b0);
    snap = {rsp_c, rsp_z, rsp_s, rsp_o, rsp_result};
    ok = 1;
    a = rand128();
    b = rand128();
    req_opsel = OP_SUB;
    req_cin   = 1'b1;
    req_a     = a;
    req_b     = b;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({rsp_c, rsp_z, rsp_s, rsp_o, rsp_result} !== snap || req_ready !== 1'b0 ||
          rsp_valid !== 1'b1) ok = 0;
    end
    check("bp held stable", 132'(ok), 132'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp back to idle", 132'({req_ready, rsp_valid, busy}), 132'(3'b100));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp next accepted", 132'({req_ready, busy}), 132'(2'b01));
    wait_and_check("bp second", ref_op(1'b1, OP_SUB, 1'b1, a, b), 1'b1, 1'b0);
    @(posedge clk); #1;

    // Reset during word 2.
    a = rand128();
    b = rand128();
    req_mode  = 1'b1;
    req_opsel = OP_ADD;
    req_cin   = 1'b1;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midop word2 slice", 132'(alu_a), 132'(a[95:64]));
    rst_n = 1'b0;
    #1;
    check("midop reset state", 132'({req_ready, rsp_valid, busy}), 132'(3'b100));
    check("midop reset alu", 132'({alu_a, alu_b, alu_opsel, alu_mode, alu_cin}), 132'd0);
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) saw = 1;
    end
    check("midop no response", 132'(saw), 132'd0);
    do_op("after reset 5+7", 1'b1, OP_ADD, 1'b0, 128'd5, 128'd7,
          {1'b0, 1'b0, 1'b0, 1'b0, 128'd12}, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
